// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shadowed period/duty, deferred loads, one-cycle period_end pulse.
// Optional macro PWM_POLARITY_EN adds a shadowed per-channel output inversion input (pol).

module pwm_multi #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        pwm_period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    load,
`ifdef PWM_POLARITY_EN
    input  logic [NUM_CH-1:0]       pol,
`endif
    output logic [NUM_CH-1:0]       out,
    output logic                    period_end,
    output logic                    update_pending
);

    logic                    r_run;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_period_s;
    logic [NUM_CH*CNT_W-1:0] r_duty_s;
    logic [NUM_CH-1:0]       r_out;
    logic                    r_period_end;
    logic                    r_update_pending;

    logic [CNT_W-1:0]        w_last;
    logic                    w_boundary;
    logic                    w_take_shadow;
    logic [NUM_CH-1:0]       w_cmp;
    logic [NUM_CH-1:0]       w_pol_s;

    // A zero period behaves as a one-cycle period.
    assign w_last        = (r_period_s == '0) ? '0 : (r_period_s - CNT_W'(1));
    assign w_boundary    = r_run && (r_cnt == w_last);
    assign w_take_shadow = enable && (!r_run || (w_boundary && (load || r_update_pending)));

    always_comb begin
        w_cmp = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_cmp[i] = (r_cnt < r_duty_s[i*CNT_W +: CNT_W]);
        end
    end

`ifdef PWM_POLARITY_EN
    logic [NUM_CH-1:0] r_pol_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pol_s <= '0;
        end else if (w_take_shadow) begin
            r_pol_s <= pol;
        end
    end

    assign w_pol_s = r_pol_s;
`else
    assign w_pol_s = '0;
`endif

    // Shadows change only at start or at a wrap, so the counter can never overrun a shrunk period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_s <= '0;
            r_duty_s   <= '0;
        end else if (w_take_shadow) begin
            r_period_s <= pwm_period;
            r_duty_s   <= duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run            <= 1'b0;
            r_cnt            <= '0;
            r_out            <= '0;
            r_period_end     <= 1'b0;
            r_update_pending <= 1'b0;
        end else if (!enable) begin
            r_run            <= 1'b0;
            r_cnt            <= '0;
            r_out            <= w_pol_s;
            r_period_end     <= 1'b0;
            r_update_pending <= 1'b0;
        end else if (!r_run) begin
            r_run            <= 1'b1;
            r_cnt            <= '0;
            r_out            <= w_pol_s;
            r_period_end     <= 1'b0;
            r_update_pending <= 1'b0;
        end else begin
            r_out        <= w_cmp ^ w_pol_s;
            r_period_end <= w_boundary;
            r_cnt        <= w_boundary ? '0 : (r_cnt + CNT_W'(1));
            // A load in the boundary cycle is applied immediately and never shows as pending.
            if (w_boundary) begin
                r_update_pending <= 1'b0;
            end else if (load) begin
                r_update_pending <= 1'b1;
            end
        end
    end

    assign out            = r_out;
    assign period_end     = r_period_end;
    assign update_pending = r_update_pending;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (NUM_CH=4, CNT_W=8, default build without polarity).
module tb_pwm_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [7:0]  pwm_period;
    logic [31:0] duty;
    logic [3:0]  out;
    logic        period_end;
    logic        update_pending;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the current period plus the applied settings.
    int       m_per;
    int       m_duty [4];
    bit       m_run;
    int       m_pos;
    bit       m_pend;
    logic [3:0] m_out;
    bit       m_pe;

    always #5 clk = ~clk;

    pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pwm_period(pwm_period),
        .duty(duty), .load(load), .out(out), .period_end(period_end),
        .update_pending(update_pending)
    );

    task automatic model_reset();
        m_per = 0; m_run = 0; m_pos = 0; m_pend = 0; m_out = '0; m_pe = 0;
        for (int c = 0; c < 4; c++) m_duty[c] = 0;
    endtask

    task automatic model_take_live();
        m_per = int'(pwm_period);
        for (int c = 0; c < 4; c++) m_duty[c] = int'(duty[c*8 +: 8]);
    endtask

    task automatic model_step();
        int len;
        bit wrap;
        if (!rst_n) begin
            model_reset();
        end else if (!enable) begin
            m_run = 0; m_pos = 0; m_pend = 0; m_out = '0; m_pe = 0;
        end else if (!m_run) begin
            m_run = 1; m_pos = 0; m_pend = 0; m_out = '0; m_pe = 0;
            model_take_live();
        end else begin
            len  = (m_per == 0) ? 1 : m_per;
            wrap = (m_pos == len - 1);
            for (int c = 0; c < 4; c++) m_out[c] = (m_pos < m_duty[c]);
            m_pe  = wrap;
            m_pos = wrap ? 0 : m_pos + 1;
            if (wrap) begin
                if (load || m_pend) model_take_live();
                m_pend = 0;
            end else if (load) begin
                m_pend = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 0; load = 0; pwm_period = 8'd0; duty = '0;
        model_reset();
        #2;
        for (int k = 0; k < 8; k++) begin
            enable = 1'($urandom); load = 1'($urandom);
            pwm_period = 8'($urandom); duty = $urandom;
            tick();
            checks++;
            if ({out, period_end, update_pending} !== 6'b0) begin
                failures++;
                $display("FAIL reset_hold k=%0d out=%b pe=%b pend=%b expected all zero", k, out, period_end, update_pending);
            end
        end
        enable = 1; load = 0; pwm_period = 8'd5; duty = 32'h0505_0505;
        rst_n = 1;
        tick(); tick();
        checks++;
        if (out !== 4'hF || out !== m_out) begin
            failures++;
            $display("FAIL reset_prerun out=%b expected %b", out, m_out);
        end
        #3;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({out, period_end, update_pending} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async out=%b pe=%b pend=%b expected all zero", out, period_end, update_pending);
        end
        tick();
        enable = 0; rst_n = 1;
        tick();
    endtask

    task automatic test_basic_run();
        int pe_cnt, ch0_hi, ch1_hi, ch23_hi;
        pe_cnt = 0; ch0_hi = 0; ch1_hi = 0; ch23_hi = 0;
        pwm_period = 8'd13;
        duty = {8'd20, 8'd13, 8'd4, 8'd0};
        enable = 1;
        tick();
        checks++;
        if (out !== 4'b0000) begin
            failures++;
            $display("FAIL basic_start out=%b expected 0000", out);
        end
        for (int k = 1; k <= 39; k++) begin
            tick();
            checks++;
            if ({out, period_end, update_pending} !== {m_out, m_pe, m_pend}) begin
                failures++;
                $display("FAIL basic_model k=%0d out=%b pe=%b pend=%b expected %b %b %b",
                         k, out, period_end, update_pending, m_out, m_pe, m_pend);
            end
            pe_cnt  += int'(period_end);
            ch0_hi  += int'(out[0]);
            ch1_hi  += int'(out[1]);
            ch23_hi += int'(out[2]) + int'(out[3]);
            if (k == 1) begin
                checks++;
                if (out[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_ch1_first out1=%b expected 1", out[1]);
                end
            end
        end
        checks++;
        if (pe_cnt != 3 || ch0_hi != 0 || ch1_hi != 12 || ch23_hi != 78) begin
            failures++;
            $display("FAIL basic_counts pe=%0d ch0=%0d ch1=%0d ch23=%0d expected 3 0 12 78",
                     pe_cnt, ch0_hi, ch1_hi, ch23_hi);
        end
    endtask

    task automatic test_deferred_load();
        int hi, guard;
        guard = 0;
        while (!(m_pos == 0 && m_pe) && guard < 30) begin
            tick(); guard++;
        end
        checks++;
        if (guard >= 30) begin
            failures++;
            $display("FAIL deferred_sync timeout pos=%0d expected boundary", m_pos);
        end
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            tick(); hi += int'(out[1]);
        end
        duty = {8'd20, 8'd13, 8'd8, 8'd0};
        load = 1;
        for (int k = 0; k < 7; k++) begin
            tick();
            load = 0;
            hi += int'(out[1]);
            checks++;
            if (update_pending !== 1'b1 || {out, period_end} !== {m_out, m_pe}) begin
                failures++;
                $display("FAIL deferred_pending k=%0d pend=%b out=%b pe=%b expected 1 %b %b",
                         k, update_pending, out, period_end, m_out, m_pe);
            end
        end
        tick();
        hi += int'(out[1]);
        checks++;
        if (update_pending !== 1'b0 || period_end !== 1'b1 || hi != 4) begin
            failures++;
            $display("FAIL deferred_apply pend=%b pe=%b ch1_high=%0d expected 0 1 4", update_pending, period_end, hi);
        end
        hi = 0;
        for (int k = 0; k < 13; k++) begin
            tick(); hi += int'(out[1]);
        end
        checks++;
        if (hi != 8 || period_end !== 1'b1) begin
            failures++;
            $display("FAIL deferred_new_duty ch1_high=%0d pe=%b expected 8 1", hi, period_end);
        end
    endtask

    task automatic test_boundary_load();
        int guard, n;
        guard = 0;
        while (m_pos != 12 && guard < 30) begin
            tick(); guard++;
        end
        pwm_period = 8'd10;
        load = 1;
        tick();
        load = 0;
        checks++;
        if (update_pending !== 1'b0 || period_end !== 1'b1) begin
            failures++;
            $display("FAIL boundary_load pend=%b pe=%b expected 0 1", update_pending, period_end);
        end
        n = 0;
        do begin
            tick(); n++;
            checks++;
            if ({out, period_end, update_pending} !== {m_out, m_pe, m_pend}) begin
                failures++;
                $display("FAIL boundary_model n=%0d out=%b pe=%b pend=%b expected %b %b %b",
                         n, out, period_end, update_pending, m_out, m_pe, m_pend);
            end
        end while (period_end !== 1'b1 && n < 30);
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL boundary_period length=%0d expected 10", n);
        end
    endtask

    task automatic test_stop_restart();
        int guard, n, hi;
        guard = 0;
        while (m_pos != 7 && guard < 30) begin
            tick(); guard++;
        end
        enable = 0;
        tick();
        checks++;
        if (out !== 4'b0000 || period_end !== 1'b0) begin
            failures++;
            $display("FAIL stop_out out=%b pe=%b expected 0000 0", out, period_end);
        end
        load = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({out, period_end, update_pending} !== 6'b0) begin
                failures++;
                $display("FAIL stop_idle k=%0d out=%b pe=%b pend=%b expected all zero", k, out, period_end, update_pending);
            end
        end
        load = 0;
        pwm_period = 8'd6;
        duty = 32'h0000_0200;
        enable = 1;
        tick();
        n = 0; hi = 0;
        do begin
            tick(); n++; hi += int'(out[1]);
        end while (period_end !== 1'b1 && n < 20);
        checks++;
        if (n != 6 || hi != 2) begin
            failures++;
            $display("FAIL restart_period length=%0d ch1_high=%0d expected 6 2", n, hi);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(99) == 0) begin
                rst_n = 0;
                model_reset();
            end else begin
                rst_n = 1;
            end
            enable = ($urandom_range(99) >= 3);
            load   = ($urandom_range(9) == 0);
            if ($urandom_range(7) == 0) pwm_period = 8'($urandom_range(20));
            if ($urandom_range(5) == 0) begin
                for (int c = 0; c < 4; c++) duty[c*8 +: 8] = 8'($urandom_range(22));
            end
            tick();
            checks++;
            if ({out, period_end, update_pending} !== {m_out, m_pe, m_pend}) begin
                failures++;
                $display("FAIL random_model k=%0d out=%b pe=%b pend=%b expected %b %b %b",
                         k, out, period_end, update_pending, m_out, m_pe, m_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_deferred_load();
        test_boundary_load();
        test_stop_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent PWM channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of period counter and duty values.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  level; high runs the generator, low idles it.
REQ-007 SHALL have port pwm_period  input  CNT_W  live period value, in clk cycles.
REQ-008 SHALL have port duty  input  NUM_CH*CNT_W  live duty per channel; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port load  input  1  one-cycle strobe requesting a shadow update.
REQ-010 SHALL have port out  output  NUM_CH  registered PWM outputs.
REQ-011 SHALL have port period_end  output  1  registered one-cycle pulse per completed period.
REQ-012 SHALL have port update_pending  output  1  high while a load request awaits a period boundary.

Function
REQ-013 SHALL hold shadow registers period_s and duty_s[i]; only shadows drive counting and comparison.
REQ-014 SHALL treat a period_s value of 0 as 1.
REQ-015 Counter cnt SHALL count 0..period_s-1 and then wrap to 0.
REQ-016 The boundary cycle SHALL be run=1 and cnt==period_s-1.
REQ-017 Start: when enable=1 and run=0 at a clock edge -> run<=1, cnt<=0, shadows<=live inputs, update_pending<=0.
REQ-018 Stop: when enable=0 at a clock edge -> run<=0, cnt<=0, out<=idle level on the same edge, and any pending load is discarded.
REQ-019 Each edge SHALL register out[i] <= run && (cnt < duty_s[i]); out lags cnt by exactly one cycle.
REQ-020 Boundary cases: duty_s=0 gives constant low; duty_s>=period_s gives constant high with no glitch at the wrap.
REQ-021 A load while run=1 SHALL set update_pending; at the next boundary edge, shadows<=live inputs and update_pending<=0.
REQ-022 Load arriving in the boundary cycle SHALL be applied on that same edge; update_pending never rises.
REQ-023 A load while run=0 SHALL be ignored.
REQ-024 period_end SHALL be registered high for exactly one cycle following each boundary cycle, aligned with out.
REQ-025 Shrinking period_s below the current cnt SHALL NOT be possible, because shadows change only at a wrap or at start.

Reset
REQ-026 rst_n low SHALL immediately, without a clock, force cnt=0, run=0, shadows=0, out=idle level, period_end=0, update_pending=0.
REQ-027 rst_n release SHALL take effect at the first clk edge; with enable already high, the start sequence of REQ-017 occurs on that edge.

Configuration
REQ-028 Macro PWM_POLARITY_EN SHALL add input pol (NUM_CH bits), shadowed with duty; out[i] is then XORed with pol_s[i], including the idle level.
REQ-029 Without PWM_POLARITY_EN, the pol port SHALL be absent and the idle level SHALL be 0.

Verification (NUM_CH=4, CNT_W=8)
REQ-030 Scenario, reset: hold rst_n=0 and toggle inputs -> out=0, period_end=0, update_pending=0; asserting rst_n mid-run clears out with no clock edge.
REQ-031 Scenario, basic run: period=13, duty ch0..3=0,4,13,20, enable raised -> ch0 always low; ch1 high 4 of 13 cycles, starting one cycle after start; ch2 and ch3 always high; period_end every 13 cycles.
REQ-032 Scenario, deferred load: period=13, duty1=4, load with duty1=8 at cnt=5 -> update_pending high for cycles cnt=6..12; ch1 is 4 high that period, then 8 high from the next.
REQ-033 Scenario, load on boundary: load at cnt=12 with period=10 -> update_pending stays 0; next period is 10 cycles.
REQ-034 Scenario, stop/restart: enable dropped at cnt=7 -> out=0 on the next edge and no period_end; re-enable -> cnt restarts at 0 and shadows reload.
REQ-035 Scenario, polarity: with PWM_POLARITY_EN, pol=4'b0010, duty1=4, period=13 -> ch1 low 4 of 13 cycles and high while idle.
